// File: rtl/matrix_make_param_if.sv
// Element-stream and matrix-result bundle for matrix_make_param.
// master drives make/dims/elements; slave returns ready, status and the assembled matrix.
interface matrix_make_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_M  = 8,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned DIM_W  = 8
);
  logic                             make;
  logic [DIM_W-1:0]                 m_dim;
  logic [DIM_W-1:0]                 n_dim;
  logic                             col_major;
  logic                             in_valid;
  logic [DATA_W-1:0]                in_data;
  logic                             in_ready;
  logic [MAX_M*MAX_N*DATA_W-1:0]    matrix_out;
  logic                             busy;
  logic                             done;
  logic                             err;

  modport master (
    output make, m_dim, n_dim, col_major, in_valid, in_data,
    input  in_ready, matrix_out, busy, done, err
  );

  modport slave (
    input  make, m_dim, n_dim, col_major, in_valid, in_data,
    output in_ready, matrix_out, busy, done, err
  );
endinterface

// File: rtl/matrix_make_param.sv
// Assembles a run-time sized M x N matrix from a valid/ready element stream into one flat bus.
// Optional MATRIX_MAKE_ZERO_FILL_EN: an accepted make clears the whole matrix before loading.
module matrix_make_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_M  = 8,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  matrix_make_param_if.slave bus
);

  localparam int unsigned SLOTS  = MAX_M * MAX_N;
  localparam int unsigned IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned BEAT_W = 2 * DIM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]              m_q, n_q, r_q, c_q;
  logic                          col_major_q;
  logic [BEAT_W-1:0]             beat_q, total_q;
  logic [SLOTS-1:0][DATA_W-1:0]  mat_q;

  logic in_ready_q, busy_q, done_q, err_q;
  logic in_ready_d, busy_d, done_d, err_d;

  logic             dims_ok_c;
  logic             start_c;
  logic             accept_c;
  logic             last_beat_c;
  logic             row_wrap_c;
  logic             col_wrap_c;
  logic [IDX_W-1:0] idx_c;

  // Full-width unsigned range check; widened so MAX_* never truncates
  assign dims_ok_c = (bus.m_dim != '0) && (64'(bus.m_dim) <= 64'(MAX_M)) &&
                     (bus.n_dim != '0) && (64'(bus.n_dim) <= 64'(MAX_N));

  assign accept_c    = (state_q == LOAD) && bus.in_valid && in_ready_q;
  assign last_beat_c = (beat_q == total_q - BEAT_W'(1));
  assign row_wrap_c  = (c_q == n_q - DIM_W'(1));
  assign col_wrap_c  = (r_q == m_q - DIM_W'(1));
  assign idx_c       = IDX_W'(64'(r_q) * 64'(MAX_N) + 64'(c_q));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next registered status
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    err_d      = 1'b0;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.make) begin
          if (dims_ok_c) begin
            start_c = 1'b1;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept_c && last_beat_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Dimension latch, fill counters and matrix storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q         <= '0;
      n_q         <= '0;
      col_major_q <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      beat_q      <= '0;
      total_q     <= '0;
      mat_q       <= '0;
    end else if (start_c) begin
      m_q         <= bus.m_dim;
      n_q         <= bus.n_dim;
      col_major_q <= bus.col_major;
      r_q         <= '0;
      c_q         <= '0;
      beat_q      <= '0;
      total_q     <= BEAT_W'(bus.m_dim) * BEAT_W'(bus.n_dim);
`ifdef MATRIX_MAKE_ZERO_FILL_EN
      mat_q       <= '0;
`endif
    end else if (accept_c) begin
      mat_q[idx_c] <= bus.in_data;
      if (last_beat_c) begin
        // Park counters at the origin so the next load starts clean
        r_q    <= '0;
        c_q    <= '0;
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
        if (!col_major_q) begin
          if (row_wrap_c) begin
            c_q <= '0;
            r_q <= r_q + DIM_W'(1);
          end else begin
            c_q <= c_q + DIM_W'(1);
          end
        end else begin
          if (col_wrap_c) begin
            r_q <= '0;
            c_q <= c_q + DIM_W'(1);
          end else begin
            r_q <= r_q + DIM_W'(1);
          end
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.matrix_out = mat_q;

endmodule

// File: tb/tb_matrix_make_param.sv
// Scoreboard bench for matrix_make_param: expected element writes are queued as beats are
// driven and checked against matrix_out on the done pulse; a shadow matrix covers untouched slots.
module tb_matrix_make_param;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_M  = 8;
  localparam int unsigned MAX_N  = 8;
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned SLOTS  = MAX_M * MAX_N;

  typedef struct packed {
    int unsigned       slot;
    logic [DATA_W-1:0] val;
  } exp_t;

  logic clk_tb = 1'b0;
  logic reset;

  always #5 clk_tb = ~clk_tb;

  matrix_make_param_if #(
    .DATA_W(DATA_W), .MAX_M(MAX_M), .MAX_N(MAX_N), .DIM_W(DIM_W)
  ) bus ();

  matrix_make_param #(
    .DATA_W(DATA_W), .MAX_M(MAX_M), .MAX_N(MAX_N), .DIM_W(DIM_W)
  ) dut (
    .clk   (clk_tb),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model[SLOTS];
  int                n_checks = 0;
  int                n_fail   = 0;

  function automatic logic [DATA_W-1:0] slot_val(input int s);
    return bus.matrix_out[s*DATA_W +: DATA_W];
  endfunction

  function automatic int model_diffs();
    int d = 0;
    for (int s = 0; s < int'(SLOTS); s++) begin
      if (slot_val(s) !== model[s]) d++;
    end
    return d;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < int'(SLOTS); s++) model[s] = '0;
  endfunction

  // Issue a make, stream elements per the valid pattern, score the result at done
  task automatic load_matrix(input int m, input int n, input bit cm,
                             input logic [DATA_W-1:0] vals[$], input bit pat[$],
                             output int done_at, output int done_cnt);
    int   r = 0;
    int   c = 0;
    int   vi = 0;
    int   pi = 0;
    bit   v;
    exp_t e;
    bus.make      = 1'b1;
    bus.m_dim     = DIM_W'(m);
    bus.n_dim     = DIM_W'(n);
    bus.col_major = cm;
`ifdef MATRIX_MAKE_ZERO_FILL_EN
    model_clear();
`endif
    exp_q.delete();
    @(negedge clk_tb);
    bus.make = 1'b0;
    done_at  = -1;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = cyc;
          n_checks++;
          if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle_flags: in_ready=%b busy=%b, required 0 0", bus.in_ready, bus.busy);
          end
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (slot_val(int'(e.slot)) !== e.val) begin
              n_fail++;
              $display("FAIL element_slot_%0d: got %0h required %0h", e.slot, slot_val(int'(e.slot)), e.val);
            end
          end
          n_checks++;
          if (model_diffs() != 0) begin
            n_fail++;
            $display("FAIL full_matrix: %0d slots differ from required contents", model_diffs());
          end
        end
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      bus.in_valid = 1'b0;
      if (vi < vals.size()) begin
        v = (pi < pat.size()) ? pat[pi] : 1'b1;
        pi++;
        if (v) begin
          bus.in_valid = 1'b1;
          bus.in_data  = vals[vi];
          e.slot = 32'(r * int'(MAX_N) + c);
          e.val  = vals[vi];
          exp_q.push_back(e);
          model[e.slot] = vals[vi];
          vi++;
          if (!cm) begin
            c++;
            if (c == n) begin c = 0; r++; end
          end else begin
            r++;
            if (r == m) begin r = 0; c++; end
          end
        end
      end
      @(negedge clk_tb);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_pulse_count: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_tb);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b busy=%b done=%b err=%b required all 0",
               bus.in_ready, bus.busy, bus.done, bus.err);
    end
    n_checks++;
    if (bus.matrix_out !== '0) begin
      n_fail++;
      $display("FAIL reset_matrix: matrix_out nonzero, required 0");
    end
    reset = 1'b1;
    model_clear();
    @(negedge clk_tb);
  endtask

  task automatic test_row_major();
    logic [DATA_W-1:0] vals[$];
    bit                none[$];
    int                slots[6] = '{0, 1, 8, 9, 16, 17};
    int                da, dc;
    vals = '{1, 2, 3, 4, 5, 6};
    load_matrix(3, 2, 1'b0, vals, none, da, dc);
    n_checks++;
    if (da != 7) begin
      n_fail++;
      $display("FAIL row_major_latency: done at cycle %0d required 7", da);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (slot_val(slots[i]) !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL row_major_slot_%0d: got %0h required %0h", slots[i], slot_val(slots[i]), i + 1);
      end
    end
  endtask

  task automatic test_col_major();
    logic [DATA_W-1:0] vals[$];
    bit                none[$];
    int                slots[6] = '{0, 8, 1, 9, 2, 10};
    int                da, dc;
    vals = '{1, 2, 3, 4, 5, 6};
    load_matrix(2, 3, 1'b1, vals, none, da, dc);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (slot_val(slots[i]) !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL col_major_slot_%0d: got %0h required %0h", slots[i], slot_val(slots[i]), i + 1);
      end
    end
  endtask

  task automatic test_invalid_dims();
    int ms[4] = '{0, 9, 3, 2};
    int ns[4] = '{4, 2, 0, 9};
    for (int i = 0; i < 4; i++) begin
      bus.make  = 1'b1;
      bus.m_dim = DIM_W'(ms[i]);
      bus.n_dim = DIM_W'(ns[i]);
      @(negedge clk_tb);
      bus.make = 1'b0;
      n_checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_%0dx%0d_pulse: err=%b busy=%b in_ready=%b required 1 0 0",
                 ms[i], ns[i], bus.err, bus.busy, bus.in_ready);
      end
      @(negedge clk_tb);
      n_checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_%0dx%0d_after: err=%b busy=%b required 0 0", ms[i], ns[i], bus.err, bus.busy);
      end
      n_checks++;
      if (model_diffs() != 0) begin
        n_fail++;
        $display("FAIL reject_%0dx%0d_matrix: %0d slots changed, required 0", ms[i], ns[i], model_diffs());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] vals[$];
    bit                pat[$];
    int                da, dc;
    vals = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    load_matrix(2, 2, 1'b0, vals, pat, da, dc);
    n_checks++;
    if (da != 8) begin
      n_fail++;
      $display("FAIL backpressure_latency: done at cycle %0d required 8", da);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [DATA_W-1:0] vals[$];
    bit                none[$];
    bit                seen_done = 1'b0;
    int                da, dc;
    bus.make      = 1'b1;
    bus.m_dim     = DIM_W'(3);
    bus.n_dim     = DIM_W'(2);
    bus.col_major = 1'b0;
    @(negedge clk_tb);
    bus.make = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(32'h100 + i);
      @(negedge clk_tb);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk_tb);
    reset = 1'b1;
    model_clear();
    n_checks++;
    if (bus.matrix_out !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b in_ready=%b matrix_zero=%b required 0 0 1",
               bus.busy, bus.in_ready, bus.matrix_out == '0);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clk_tb);
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL midload_no_done: got done pulse, required none");
    end
    vals = '{21, 22, 23, 24, 25, 26};
    load_matrix(3, 2, 1'b0, vals, none, da, dc);
    n_checks++;
    if (da != 7) begin
      n_fail++;
      $display("FAIL reload_latency: done at cycle %0d required 7", da);
    end
  endtask

  task automatic test_zero_fill();
    logic [DATA_W-1:0] vals[$];
    bit                none[$];
    logic [DATA_W-1:0] want;
    int                da, dc;
    vals = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    load_matrix(3, 3, 1'b0, vals, none, da, dc);
    vals = '{5, 5, 5, 5};
    load_matrix(2, 2, 1'b0, vals, none, da, dc);
`ifdef MATRIX_MAKE_ZERO_FILL_EN
    want = DATA_W'(0);
`else
    want = DATA_W'(7);
`endif
    n_checks++;
    if (slot_val(2) !== want) begin
      n_fail++;
      $display("FAIL zero_fill_slot_2: got %0h required %0h", slot_val(2), want);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.make      = 1'b0;
    bus.m_dim     = '0;
    bus.n_dim     = '0;
    bus.col_major = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    @(negedge clk_tb);
    test_reset();
    test_row_major();
    test_col_major();
    test_invalid_dims();
    test_backpressure();
    test_reset_mid_load();
    test_zero_fill();
    repeat (2) @(negedge clk_tb);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matrix_make_param.md
Name: matrix_make_param

Overview:
- Parametrised successor to the fixed 128x128 matrix builder.
- Assembles an M x N matrix, with M and N chosen at run time up to MAX_M x MAX_N, from a valid/ready element stream into one flat output bus.
- Supports row-major or column-major fill order, dimension checking, and a done/err status.
- Sits upstream of the linear-equation solver matrix blocks, which consume matrix_out directly.

Parameters:
- DATA_W, 32: element width in bits.
- MAX_M, 8: maximum row count.
- MAX_N, 8: maximum column count.
- DIM_W, 8: width of the dimension inputs.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
- make  input  1  start request; sampled only in IDLE.
- m_dim  input  DIM_W  row count, latched on an accepted make.
- n_dim  input  DIM_W  column count, latched on an accepted make.
- col_major  input  1  fill order, latched on an accepted make: 0 = row-major, 1 = column-major.
- in_valid  input  1  in_data holds a valid element.
- in_data  input  DATA_W  element value.
- in_ready  output  1  block accepts an element this cycle.
- matrix_out  output  MAX_M*MAX_N*DATA_W  element (r,c) at bits [(r*MAX_N+c)*DATA_W +: DATA_W].
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the matrix is complete.
- err  output  1  one-cycle pulse when make is rejected.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; matrix_out=0; in_ready=0, busy=0, done=0, err=0.
  - Row/column/beat counters=0.
  - Applies from any state, including mid-LOAD; a partial load is discarded.
- All outputs are registered.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - make=1 with 1<=m_dim<=MAX_M and 1<=n_dim<=MAX_N: latch m_dim, n_dim, col_major; set r=c=0; go to LOAD.
  - make=1 with either dimension 0 or above its maximum: err=1 for exactly the next cycle; stay in IDLE; matrix_out unchanged.
  - make=0: stay in IDLE.
- LOAD:
  - in_ready=1 and busy=1.
  - A beat is accepted when in_valid=1 && in_ready=1; element (r,c) <= in_data.
  - Row-major: c increments; when c=n_dim-1, c wraps to 0 and r increments.
  - Column-major: r increments; when r=m_dim-1, r wraps to 0 and c increments.
  - After the m_dim*n_dim-th accepted beat, go to DONE.
  - in_valid=0 cycles are gaps: counters hold and nothing is written.
  - make is ignored in LOAD.
- DONE:
  - Lasts exactly one cycle: done=1, in_ready=0, busy=0; then IDLE.
  - done is high in the cycle immediately after the edge that accepted the last beat.
  - Minimum make-to-done latency is m_dim*n_dim+1 cycles after the make edge.
  - make asserted in DONE is ignored; it is re-sampled only in IDLE.
- matrix_out holds its value after done until the next accepted make (see the optional feature) or reset.
- Elements outside the active m_dim x n_dim region are never written during LOAD.
- A 1x1 matrix takes a single beat, then DONE.
- Dimension compare is unsigned over the full DIM_W bits.

Optional Feature:
- Macro: MATRIX_MAKE_ZERO_FILL_EN.
- Defined: on the edge that accepts make, the entire matrix_out is cleared to 0, so entries outside the new m_dim x n_dim region read 0 after done.
- Undefined: an accepted make does not touch matrix_out; entries outside the active region keep values from the previous matrix (or 0 after reset).
- Rejected makes never clear matrix_out, with or without the macro.

Test Plan:
- Row-major fill, defaults: reset low 1 cycle; make with m=3, n=2, col_major=0; stream 1..6 back-to-back. Required: element slots 0,1,8,9,16,17 = 1,2,3,4,5,6; done high exactly 7 cycles after the make edge; in_ready=0 in the DONE cycle.
- Column-major fill: make with m=2, n=3, col_major=1; stream 1..6. Required: slots 0,8,1,9,2,10 = 1,2,3,4,5,6, i.e. (0,0)=1, (1,0)=2, (0,1)=3.
- Invalid dimensions:
  - m=0, n=4: err pulse of 1 cycle; busy stays 0; matrix_out unchanged.
  - m=9 with MAX_M=8: same response.
- Backpressure gaps: m=2, n=2; in_valid pattern 1,0,0,1,0,1,1 with values A,-,-,B,-,C,D. Required: (0,0)=A, (0,1)=B, (1,0)=C, (1,1)=D; done exactly once.
- Reset mid-load: reset=0 after 3 of 6 beats. Required: matrix_out=0 and IDLE next cycle, no done pulse; a fresh 3x2 load then completes correctly.
- Zero fill:
  - Load 3x3 with all elements 7, then load 2x2 with all elements 5.
  - MATRIX_MAKE_ZERO_FILL_EN defined: slot 2 (element (0,2)) = 0.
  - MATRIX_MAKE_ZERO_FILL_EN undefined: slot 2 = 7.
